// File: rtl/data_mem_ctrl.sv
// Load/store controller for a single-port synchronous SRAM of 19-bit words.
// Partial stores run as read-modify-write; wait states are set by WAIT_CYC.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_i,
  input  logic [18:0]       addr_i,
  input  logic [1:0]        byte_en_i,
  input  logic              wr_i,
  input  logic [18:0]       wr_data_i,
  output logic [18:0]       rd_data_o,
  output logic              ready_o,
  output logic              err_o,
  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [18:0]       sram_wdata_o,
  input  logic [18:0]       sram_rdata_i
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdWait,
    StWr,
    StWrWait,
    StResp
  } state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYC);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        be_q;
  logic              wr_q;
  logic [18:0]       wdata_q;
  logic [18:0]       rdata_q;
  logic              rmw_q;
  logic              err_q;
  logic [3:0]        wait_cnt;
  logic              ready_q;
  logic              sram_en_q;
  logic              sram_we_q;
  logic [18:0]       sram_wdata_q;

  logic out_of_range;
  logic partial;

  assign out_of_range = (addr_i >> ADDR_W) != '0;
  assign partial      = ~byte_en_i[1];

  // Insert the store data into the old word; 2'b10 and 2'b11 replace the whole word.
  function automatic logic [18:0] merge(input logic [1:0]  be,
                                        input logic [18:0] old_w,
                                        input logic [18:0] new_w);
    logic [18:0] res;
    case (be)
      2'b00:   res = {old_w[18:8], new_w[7:0]};
      2'b01:   res = {old_w[18:16], new_w[15:0]};
      default: res = new_w;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      be_q         <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rmw_q        <= 1'b0;
      err_q        <= 1'b0;
      wait_cnt     <= '0;
      ready_q      <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_wdata_q <= '0;
    end else begin
      // Strobes and the completion pulse last one cycle unless a transition re-asserts them.
      ready_q      <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_wdata_q <= '0;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            addr_q  <= addr_i[ADDR_W-1:0];
            be_q    <= byte_en_i;
            wr_q    <= wr_i;
            wdata_q <= wr_data_i;
            if (out_of_range) begin
              err_q   <= 1'b1;
              ready_q <= 1'b1;
              state_q <= StResp;
            end else if (!wr_i || partial) begin
              rmw_q     <= wr_i;
              sram_en_q <= 1'b1;
              state_q   <= StRd;
            end else begin
              sram_en_q    <= 1'b1;
              sram_we_q    <= 1'b1;
              sram_wdata_q <= wr_data_i;
              state_q      <= StWr;
            end
          end
        end
        StRd: begin
          wait_cnt <= WaitInit;
          state_q  <= StRdWait;
        end
        StRdWait: begin
          if (wait_cnt == 4'd0) begin
            rdata_q <= sram_rdata_i;
            if (rmw_q) begin
              sram_en_q    <= 1'b1;
              sram_we_q    <= 1'b1;
              sram_wdata_q <= merge(be_q, sram_rdata_i, wdata_q);
              state_q      <= StWr;
            end else begin
              ready_q <= 1'b1;
              state_q <= StResp;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        StWr: begin
          if (WaitInit == 4'd0) begin
            ready_q <= 1'b1;
            state_q <= StResp;
          end else begin
            wait_cnt <= WaitInit;
            state_q  <= StWrWait;
          end
        end
        StWrWait: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            ready_q <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          rmw_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o      = ready_q;
  assign err_o        = ready_q & err_q;
  assign rd_data_o    = (ready_q && !wr_q && !err_q) ? rdata_q : '0;
  assign sram_en_o    = sram_en_q;
  assign sram_we_o    = sram_we_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = sram_wdata_q;

endmodule
